// File: rtl/zwolf_mem_arbiter_pkg.sv
// zwolf_mem_arbiter_pkg: shared widths, FSM state encoding and timeout default
// for the two-port memory arbiter.
package zwolf_mem_arbiter_pkg;
    localparam int ADDR_W      = 13;
    localparam int DATA_W      = 8;
    localparam int TIMEOUT_DEF = 255;
    typedef enum logic [1:0] {
        ARB_IDLE = 2'd0,
        ARB_REQ  = 2'd1,
        ARB_DONE = 2'd2
    } arb_state_t;
endpackage

// File: rtl/zwolf_mem_arbiter_if.sv
// zwolf_mem_arbiter_if: valid/ready memory request bus shared by the requesters
// and the memory side. The master issues requests; the slave completes them.
interface zwolf_mem_arbiter_if;
    import zwolf_mem_arbiter_pkg::*;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
    logic              write;
    logic              valid;
    logic              ready;
    logic [DATA_W-1:0] rdata;
    modport master (output addr, wdata, write, valid, input ready, rdata);
    modport slave  (input addr, wdata, write, valid, output ready, rdata);
endinterface

// File: rtl/zwolf_rr_pick.sv
// zwolf_rr_pick: combinational 2-way round-robin winner; on a tie the port
// that did not own the last transaction wins.
module zwolf_rr_pick (
    input  logic [1:0] i_valid,
    input  logic       i_last,
    output logic       o_any,
    output logic       o_win
);
    assign o_any = |i_valid;
    assign o_win = &i_valid ? ~i_last : i_valid[1];
endmodule

// File: rtl/zwolf_mem_arbiter.sv
// zwolf_mem_arbiter: shares one memory between the CPU (m0) and host (m1), one
// transaction in flight. Optional memory-wait abort under ZWOLF_ARB_TIMEOUT_EN.
module zwolf_mem_arbiter
    import zwolf_mem_arbiter_pkg::*;
`ifdef ZWOLF_ARB_TIMEOUT_EN
    #(parameter int TIMEOUT = TIMEOUT_DEF)
`endif
(
    input  logic                i_clk,
    input  logic                i_resetn,
    zwolf_mem_arbiter_if.slave  m0,
    zwolf_mem_arbiter_if.slave  m1,
    zwolf_mem_arbiter_if.master mem,
    output logic                o_grant,
    output logic                o_busy
`ifdef ZWOLF_ARB_TIMEOUT_EN
    ,
    output logic                o_timeout_err
`endif
);
    arb_state_t        r_state;
    logic [ADDR_W-1:0] r_addr;
    logic [DATA_W-1:0] r_wdata;
    logic              r_write;
    logic              r_valid;
    logic              r_grant;
    logic              r_busy;
    logic [1:0]        r_ready;
    logic [DATA_W-1:0] r_rdata [2];
    logic              w_any;
    logic              w_win;
    logic              w_abort;
    logic              w_done;

    zwolf_rr_pick u_pick (
        .i_valid ({m1.valid, m0.valid}),
        .i_last  (r_grant),
        .o_any   (w_any),
        .o_win   (w_win)
    );

`ifdef ZWOLF_ARB_TIMEOUT_EN
    logic [7:0] r_wait;
    logic       r_tmo;
    assign w_abort       = !mem.ready && r_wait == 8'(TIMEOUT - 1);
    assign o_timeout_err = r_tmo;
    always_ff @(posedge i_clk or negedge i_resetn) begin
        if (!i_resetn) begin
            r_wait <= '0;
            r_tmo  <= 1'b0;
        end else begin
            r_wait <= (r_state == ARB_REQ) ? r_wait + 8'd1 : 8'd0;
            if (r_state == ARB_REQ && w_abort) r_tmo <= 1'b1;
        end
    end
`else
    assign w_abort = 1'b0;
`endif

    assign w_done = mem.ready | w_abort;

    always_ff @(posedge i_clk or negedge i_resetn) begin
        if (!i_resetn) begin
            r_state    <= ARB_IDLE;
            r_addr     <= '0;
            r_wdata    <= '0;
            r_write    <= 1'b0;
            r_valid    <= 1'b0;
            r_grant    <= 1'b1;
            r_busy     <= 1'b0;
            r_ready    <= 2'b00;
            r_rdata[0] <= '0;
            r_rdata[1] <= '0;
        end else begin
            case (r_state)
                ARB_IDLE: if (w_any) begin
                    r_addr  <= w_win ? m1.addr : m0.addr;
                    r_wdata <= w_win ? m1.wdata : m0.wdata;
                    r_write <= w_win ? m1.write : m0.write;
                    r_valid <= 1'b1;
                    r_grant <= w_win;
                    r_busy  <= 1'b1;
                    r_state <= ARB_REQ;
                end
                ARB_REQ: if (w_done) begin
                    // a timed-out access reports all-ones even for writes
                    r_valid <= 1'b0;
                    r_write <= 1'b0;
                    if (w_abort || !r_write) r_rdata[r_grant] <= w_abort ? '1 : mem.rdata;
                    r_ready[r_grant] <= 1'b1;
                    r_state <= ARB_DONE;
                end
                ARB_DONE: begin
                    r_ready <= 2'b00;
                    r_busy  <= 1'b0;
                    r_state <= ARB_IDLE;
                end
                default: r_state <= ARB_IDLE;
            endcase
        end
    end

    assign mem.addr  = r_addr;
    assign mem.wdata = r_wdata;
    assign mem.write = r_write;
    assign mem.valid = r_valid;
    assign m0.ready  = r_ready[0];
    assign m1.ready  = r_ready[1];
    assign m0.rdata  = r_rdata[0];
    assign m1.rdata  = r_rdata[1];
    assign o_grant   = r_grant;
    assign o_busy    = r_busy;
endmodule

// File: tb/tb_zwolf_mem_arbiter.sv
// tb_zwolf_mem_arbiter: table-driven single transactions plus hand-written
// sequences for round-robin, mid-request reset, stray ready and timeout.
module tb_zwolf_mem_arbiter;
    import zwolf_mem_arbiter_pkg::*;

    logic clk = 1'b0;
    logic resetn;
    logic grant;
    logic busy;
    int   n_chk = 0;
    int   n_err = 0;

    zwolf_mem_arbiter_if m0_if ();
    zwolf_mem_arbiter_if m1_if ();
    zwolf_mem_arbiter_if mem_if ();

`ifdef ZWOLF_ARB_TIMEOUT_EN
    logic tmo;
    zwolf_mem_arbiter #(.TIMEOUT(16)) dut (
        .i_clk(clk), .i_resetn(resetn), .m0(m0_if), .m1(m1_if), .mem(mem_if),
        .o_grant(grant), .o_busy(busy), .o_timeout_err(tmo)
    );
`else
    zwolf_mem_arbiter dut (
        .i_clk(clk), .i_resetn(resetn), .m0(m0_if), .m1(m1_if), .mem(mem_if),
        .o_grant(grant), .o_busy(busy)
    );
`endif

    always #5 clk = ~clk;

    typedef struct {
        logic        port;
        logic        wr;
        logic [12:0] addr;
        logic [7:0]  wdata;
        int          lat;
        logic [7:0]  mrd;
        logic [7:0]  exp_rd;
    } vec_t;

    typedef struct {
        logic       port;
        logic [7:0] rd;
    } exp_t;

    vec_t vecs [6];
    exp_t sb [$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic drive(input logic p, input logic v, input logic wr,
                         input logic [12:0] a, input logic [7:0] d);
        if (p) begin
            m1_if.valid = v; m1_if.write = wr; m1_if.addr = a; m1_if.wdata = d;
        end else begin
            m0_if.valid = v; m0_if.write = wr; m0_if.addr = a; m0_if.wdata = d;
        end
    endtask

    function automatic logic rdy(input logic p);
        return p ? m1_if.ready : m0_if.ready;
    endfunction

    function automatic logic [7:0] rdat(input logic p);
        return p ? m1_if.rdata : m0_if.rdata;
    endfunction

    task automatic wait_mem(input string name);
        int i = 0;
        do begin
            @(negedge clk);
            i++;
        end while (mem_if.valid !== 1'b1 && i < 20);
        chk({name, "_mem_valid"}, mem_if.valid, 1'b1);
    endtask

    task automatic reset_pulse();
        @(negedge clk);
        resetn = 1'b0;
        @(negedge clk);
        resetn = 1'b1;
    endtask

    task automatic run(input vec_t v, input string tag);
        exp_t e;
        sb.push_back('{v.port, v.exp_rd});
        drive(v.port, 1'b1, v.wr, v.addr, v.wdata);
        wait_mem(tag);
        chk({tag, "_addr"}, mem_if.addr, v.addr);
        chk({tag, "_wdata"}, mem_if.wdata, v.wdata);
        chk({tag, "_write"}, mem_if.write, v.wr);
        chk({tag, "_grant"}, grant, v.port);
        chk({tag, "_busy"}, busy, 1'b1);
        for (int i = 1; i < v.lat; i++) begin
            @(negedge clk);
            chk({tag, "_hold_valid"}, mem_if.valid, 1'b1);
            chk({tag, "_hold_write"}, mem_if.write, v.wr);
            chk({tag, "_hold_addr"}, mem_if.addr, v.addr);
            chk({tag, "_early_ready"}, rdy(v.port), 1'b0);
        end
        mem_if.ready = 1'b1;
        mem_if.rdata = v.mrd;
        @(negedge clk);
        mem_if.ready = 1'b0;
        e = sb.pop_front();
        chk({tag, "_ready"}, rdy(e.port), 1'b1);
        chk({tag, "_rdata"}, rdat(e.port), e.rd);
        chk({tag, "_other_ready"}, rdy(!e.port), 1'b0);
        chk({tag, "_mem_drop"}, mem_if.valid, 1'b0);
        chk({tag, "_wr_drop"}, mem_if.write, 1'b0);
        drive(v.port, 1'b0, 1'b0, '0, '0);
        @(negedge clk);
        chk({tag, "_ready_pulse"}, rdy(e.port), 1'b0);
        chk({tag, "_busy_low"}, busy, 1'b0);
    endtask

    initial begin
        exp_t e;
        int   n;
        vecs[0] = '{1'b0, 1'b0, 13'h0100, 8'h00, 3, 8'h5A, 8'h5A};
        vecs[1] = '{1'b1, 1'b1, 13'h1FFF, 8'hA5, 2, 8'h3C, 8'h00};
        vecs[2] = '{1'b1, 1'b0, 13'h0ABC, 8'h00, 1, 8'hC3, 8'hC3};
        vecs[3] = '{1'b0, 1'b1, 13'h0000, 8'h77, 1, 8'hEE, 8'h5A};
        vecs[4] = '{1'b1, 1'b1, 13'h0001, 8'h11, 4, 8'h99, 8'hC3};
        vecs[5] = '{1'b0, 1'b0, 13'h1000, 8'h00, 2, 8'h00, 8'h00};
        resetn = 1'b1;
        drive(1'b0, 1'b0, 1'b0, '0, '0);
        drive(1'b1, 1'b0, 1'b0, '0, '0);
        mem_if.ready = 1'b0;
        mem_if.rdata = '0;
        #3 resetn = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_mem_valid", mem_if.valid, 1'b0);
        chk("rst_mem_write", mem_if.write, 1'b0);
        chk("rst_mem_addr", mem_if.addr, 13'h0);
        chk("rst_ready", {m1_if.ready, m0_if.ready}, 2'b00);
        chk("rst_rdata", {m1_if.rdata, m0_if.rdata}, 16'h0);
        chk("rst_grant", grant, 1'b1);
        chk("rst_busy", busy, 1'b0);
        resetn = 1'b1;

        for (int i = 0; i < 6; i++) run(vecs[i], $sformatf("vec%0d", i));

        // stray memory completion while idle
        mem_if.ready = 1'b1;
        mem_if.rdata = 8'h66;
        @(negedge clk);
        mem_if.ready = 1'b0;
        chk("stray_ready", {m1_if.ready, m0_if.ready}, 2'b00);
        chk("stray_busy", busy, 1'b0);
        chk("stray_mem_valid", mem_if.valid, 1'b0);
        @(negedge clk);
        chk("stray_busy2", busy, 1'b0);
        chk("stray_rdata", {m1_if.rdata, m0_if.rdata}, {8'hC3, 8'h00});

        // both ports held valid after reset: grants alternate starting with port 0
        reset_pulse();
        drive(1'b0, 1'b1, 1'b0, 13'h00AA, 8'h00);
        drive(1'b1, 1'b1, 1'b0, 13'h0155, 8'h00);
        for (int i = 0; i < 4; i++) sb.push_back('{logic'(i % 2), 8'(8'h10 + i)});
        for (int i = 0; i < 4; i++) begin
            wait_mem($sformatf("rr%0d", i));
            e = sb.pop_front();
            chk($sformatf("rr%0d_grant", i), grant, e.port);
            chk($sformatf("rr%0d_addr", i), mem_if.addr, e.port ? 13'h0155 : 13'h00AA);
            mem_if.ready = 1'b1;
            mem_if.rdata = e.rd;
            @(negedge clk);
            mem_if.ready = 1'b0;
            chk($sformatf("rr%0d_ready", i), rdy(e.port), 1'b1);
            chk($sformatf("rr%0d_rdata", i), rdat(e.port), e.rd);
            chk($sformatf("rr%0d_other", i), rdy(!e.port), 1'b0);
        end
        drive(1'b0, 1'b0, 1'b0, '0, '0);
        drive(1'b1, 1'b0, 1'b0, '0, '0);
        @(negedge clk);

        // reset asserted mid-request abandons the transaction at once
        drive(1'b0, 1'b1, 1'b0, 13'h0123, 8'h00);
        wait_mem("midrst");
        @(negedge clk);
        #2 resetn = 1'b0;
        #1;
        chk("midrst_mem_valid", mem_if.valid, 1'b0);
        chk("midrst_busy", busy, 1'b0);
        chk("midrst_grant", grant, 1'b1);
        chk("midrst_rdata", m0_if.rdata, 8'h00);
        drive(1'b0, 1'b0, 1'b0, '0, '0);
        @(negedge clk);
        resetn = 1'b1;
        mem_if.ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk($sformatf("midrst_noready%0d", i), {m1_if.ready, m0_if.ready}, 2'b00);
            chk($sformatf("midrst_idle%0d", i), mem_if.valid, 1'b0);
        end
        mem_if.ready = 1'b0;
        run('{1'b0, 1'b0, 13'h0042, 8'h00, 2, 8'h3C, 8'h3C}, "postrst");

`ifdef ZWOLF_ARB_TIMEOUT_EN
        drive(1'b0, 1'b1, 1'b0, 13'h0777, 8'h00);
        wait_mem("tmo");
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (m0_if.ready !== 1'b1 && n < 40);
        chk("tmo_ready", m0_if.ready, 1'b1);
        chk("tmo_cycles", n, 16);
        chk("tmo_rdata", m0_if.rdata, 8'hFF);
        chk("tmo_flag", tmo, 1'b1);
        drive(1'b0, 1'b0, 1'b0, '0, '0);
        repeat (3) @(negedge clk);
        chk("tmo_sticky", tmo, 1'b1);
        reset_pulse();
        chk("tmo_cleared", tmo, 1'b0);
`else
        n = 0;
`endif

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end
endmodule
